// File: rtl/wb_arbiter_if.sv
// Bus bundle between the result producers (ALU, long-op units), the
// write-back arbiter and the register-file write port.
//   master : result producers / register-file side
//   slave  : the write-back arbiter itself
interface wb_arbiter_if #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 64
);
  localparam int CW = $clog2(DEPTH) + 1;

  // single-cycle ALU result stream (never stalled)
  logic              AluValid;
  logic [4:0]        AluRd;
  logic [DATA_W-1:0] AluData;

  // multi-cycle long-op result stream (valid/ready)
  logic              LongValid;
  logic              LongReady;
  logic [4:0]        LongRd;
  logic [DATA_W-1:0] LongData;

  // register-file write port
  logic              RegWr;
  logic [4:0]        RW;
  logic [DATA_W-1:0] BusW;

  // hazard / status
  logic [31:0]       Pending;
  logic [CW-1:0]     Count;

  modport master (
    output AluValid, AluRd, AluData,
    output LongValid, LongRd, LongData,
    input  LongReady,
    input  RegWr, RW, BusW,
    input  Pending, Count
  );

  modport slave (
    input  AluValid, AluRd, AluData,
    input  LongValid, LongRd, LongData,
    output LongReady,
    output RegWr, RW, BusW,
    output Pending, Count
  );
endinterface

// File: rtl/wb_arbiter.sv
// Write-back arbiter in front of the 32 x DATA_W register file.
// Merges the un-stallable ALU result stream and the long-op stream onto
// the single register-file write port. Long-op results wait in a small
// FIFO; an ALU write to the same destination kills older queued writes so
// the register file never sees a write-after-write reorder.
// Optional build macro: WB_BYPASS_EN -- when the FIFO is empty and the ALU
// is idle, an accepted long result goes straight to the write port.
module wb_arbiter #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 64
) (
  input logic        Clk,
  input logic        ResetL,
  wb_arbiter_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  // x31 is the discard register: results aimed at it are never written
  localparam logic [4:0]    ZERO_REG   = 5'd31;

  // ---------------------------------------------------------------------
  // FIFO storage and control state
  // ---------------------------------------------------------------------
  logic [4:0]        rd_mem   [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [DEPTH-1:0]  live_reg;
  logic [DEPTH-1:0]  live_next;
  logic [PW-1:0]     wr_ptr_reg;
  logic [PW-1:0]     rd_ptr_reg;
  logic [CW-1:0]     count_reg;

  // registered write-port outputs
  logic              regwr_reg;
  logic [4:0]        rw_reg;
  logic [DATA_W-1:0] busw_reg;

  // per-cycle decisions
  logic              long_ready;
  logic              push;
  logic              enq;
  logic              pop;
  logic              bypass;
  logic              new_live;
  logic              fifo_empty;

  // head of the FIFO
  logic [4:0]        head_rd;
  logic [DATA_W-1:0] head_data;
  logic              head_live;

  // pending-destination bitmap
  logic [31:0]       entry_dec [DEPTH];
  logic [31:0]       pending_comb;

  // ---------------------------------------------------------------------
  // Handshake and arbitration decisions
  // ---------------------------------------------------------------------
  assign fifo_empty = (count_reg == '0);

  // Ready depends only on registered occupancy, so a pop in a full cycle
  // cannot open the door until the following cycle.
  assign long_ready = ResetL && (count_reg < FULL_COUNT);
  assign push       = bus.LongValid && long_ready;

  // The ALU cannot be stalled, so it always owns the port when valid;
  // the FIFO head drains only in ALU-idle cycles.
  assign pop = !bus.AluValid && !fifo_empty;

`ifdef WB_BYPASS_EN
  // Nothing older is queued and the port is free: skip the FIFO.
  assign bypass = push && !bus.AluValid && fifo_empty;
`else
  assign bypass = 1'b0;
`endif

  assign enq = push && !bypass;

  // A long result accepted alongside a same-destination ALU result is
  // older than it, so it enters the queue already dead.
  assign new_live = (bus.LongRd != ZERO_REG) &&
                    !(bus.AluValid && (bus.LongRd == bus.AluRd));

  assign head_rd   = rd_mem[rd_ptr_reg];
  assign head_data = data_mem[rd_ptr_reg];
  assign head_live = live_reg[rd_ptr_reg];

  // ---------------------------------------------------------------------
  // Per-entry live-bit update and destination decode
  // ---------------------------------------------------------------------
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic is_wr_slot;
    logic is_rd_slot;
    logic alu_hit;

    assign is_wr_slot = enq && (wr_ptr_reg == PW'(gi));
    assign is_rd_slot = pop && (rd_ptr_reg == PW'(gi));
    // only live entries can be killed, so stale rd_mem contents are harmless
    assign alu_hit    = bus.AluValid && live_reg[gi] && (rd_mem[gi] == bus.AluRd);

    // The write slot is never the popped slot (push needs room, pop needs
    // an entry, and they collide only when empty), so priority is safe.
    assign live_next[gi] = is_wr_slot ? new_live :
                           is_rd_slot ? 1'b0     :
                           alu_hit    ? 1'b0     :
                                        live_reg[gi];

    assign entry_dec[gi] = live_reg[gi] ? (32'd1 << rd_mem[gi]) : 32'd0;
  end

  // OR the per-entry one-hot destinations into the hazard bitmap
  always_comb begin
    pending_comb = '0;
    for (int i = 0; i < DEPTH; i++) begin
      pending_comb = pending_comb | entry_dec[i];
    end
    pending_comb[31] = 1'b0;
  end

  // ---------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------

  // Entry payload storage; contents only matter while the slot is occupied
  always_ff @(posedge Clk) begin
    if (enq) begin
      rd_mem[wr_ptr_reg]   <= bus.LongRd;
      data_mem[wr_ptr_reg] <= bus.LongData;
    end
  end

  // Live bits: cleared on reset so a mid-operation reset drops every entry
  always_ff @(posedge Clk or negedge ResetL) begin
    if (!ResetL) begin
      live_reg <= '0;
    end else begin
      live_reg <= live_next;
    end
  end

  // Pointers wrap naturally; the extra count bit separates full from empty
  always_ff @(posedge Clk or negedge ResetL) begin
    if (!ResetL) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (enq) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
      case ({enq, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Write port: one winner per cycle, RW/BusW hold when nothing is written
  always_ff @(posedge Clk or negedge ResetL) begin
    if (!ResetL) begin
      regwr_reg <= 1'b0;
      rw_reg    <= '0;
      busw_reg  <= '0;
    end else if (bus.AluValid) begin
      regwr_reg <= (bus.AluRd != ZERO_REG);
      rw_reg    <= bus.AluRd;
      busw_reg  <= bus.AluData;
    end else if (pop) begin
      if (head_live && (head_rd != ZERO_REG)) begin
        regwr_reg <= 1'b1;
        rw_reg    <= head_rd;
        busw_reg  <= head_data;
      end else begin
        regwr_reg <= 1'b0;
      end
    end else if (bypass) begin
      regwr_reg <= (bus.LongRd != ZERO_REG);
      rw_reg    <= bus.LongRd;
      busw_reg  <= bus.LongData;
    end else begin
      regwr_reg <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign bus.LongReady = long_ready;
  assign bus.RegWr     = regwr_reg;
  assign bus.RW        = rw_reg;
  assign bus.BusW      = busw_reg;
  assign bus.Pending   = pending_comb;
  assign bus.Count     = count_reg;

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Write-back arbiter directly upstream of the 64-bit, 32-entry register file.
- Merges a single-cycle ALU result stream and a multi-cycle long-op stream (loads, multiply) onto the register file's single write port.
- Drives that port as RegWr/RW/BusW, buffers long-op results in a small FIFO, and kills stale queued writes to prevent WAW reordering.
- Exports a pending-destination bitmap for hazard logic.

Parameters:
- DEPTH, 4, FIFO entries for long-op results; power of two, 2..16.
- DATA_W, 64, result data width.

Ports:
- Clk  input  1  clock; all state updates on rising edge.
- ResetL  input  1  asynchronous active-low reset.
- AluValid  input  1  ALU result valid this cycle; cannot be stalled.
- AluRd  input  5  ALU destination register.
- AluData  input  DATA_W  ALU result.
- LongValid  input  1  long-op result offered.
- LongReady  output  1  long-op result accepted when LongValid&&LongReady.
- LongRd  input  5  long-op destination register.
- LongData  input  DATA_W  long-op result.
- RegWr  output  1  register-file write enable, registered.
- RW  output  5  register-file write index, registered.
- BusW  output  DATA_W  register-file write data, registered.
- Pending  output  32  bit r=1 while a live queued write targets register r.
- Count  output  $clog2(DEPTH)+1  FIFO occupancy, including killed entries.

Behaviour:
- Interface: one clock Clk; reset ResetL is asynchronous, active-low.
- Reset state (while ResetL=0):
  - RegWr=0, RW=0, BusW=0.
  - Pending=0, Count=0.
  - FIFO pointers=0, all entry live bits cleared.
  - LongReady=0.
- Reset mid-operation discards all queued entries; nothing is written after release.
- LongReady = ResetL && (Count<DEPTH), combinational.
- Per-cycle port selection, exactly one winner, registered onto RegWr/RW/BusW at the next edge (latency 1):
  1. AluValid=1: ALU wins. RW=AluRd, BusW=AluData, RegWr=(AluRd!=31).
  2. Else FIFO non-empty: pop head. If head is live and Rd!=31, RegWr=1, RW=Rd, BusW=data. Otherwise RegWr=0, RW and BusW hold.
  3. Else no source: RegWr=0, RW and BusW hold.
- Push: an accepted long result is enqueued at the tail with live=(LongRd!=31). Push and pop may occur in the same cycle; Count is unchanged in that case.
- Full FIFO: LongReady=0. A pop in that cycle does not raise LongReady until the next cycle; no combinational ready-from-pop path.
- WAW kill (ALU result is always younger than queued entries):
  - When AluValid=1, every queued entry with Rd==AluRd has its live bit cleared at that edge.
  - A long result accepted in the same cycle with LongRd==AluRd is enqueued with live=0.
- Killed entries still occupy a slot and consume a pop cycle; they never assert RegWr.
- Pending: bit r = OR of (live && Rd==r) over all entries, updated with the FIFO state at each edge. Pending[31] is always 0.
- Pointers are $clog2(DEPTH) bits and wrap naturally; Count distinguishes full from empty.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: when the FIFO is empty, AluValid=0 and a long result is accepted, it goes straight to RegWr/RW/BusW at the next edge (latency 1). It is not enqueued, and Pending and Count stay 0.
- Undefined: every accepted long result is enqueued. Minimum long-op latency is 2 cycles (push, then pop).

Test Plan:
- Reset, then AluValid=1, AluRd=5, AluData=0x1234 for 1 cycle -> next edge RegWr=1, RW=5, BusW=0x1234; following cycle RegWr=0.
- AluValid held 1 for 6 cycles while LongValid offers Rd=1..5 -> 4 accepted, LongReady=0 after Count=4, Pending=0x1E. After ALU stops, writes to x1..x4 in order, one per cycle, then x5; Pending returns to 0.
- Queue long Rd=7 data=0xAA (ALU busy), then AluValid Rd=7 data=0xBB -> RegWr with RW=7 BusW=0xBB only. The killed entry pops with RegWr=0, Pending[7] clears at the ALU edge, and final x7=0xBB.
- AluRd=31 and LongRd=31 results -> accepted, RegWr never asserted, Pending[31]=0, Count returns to 0.
- FIFO with 3 entries, ResetL pulsed low asynchronously between edges -> outputs 0 immediately; after release no writes occur and Count=0.
- Empty FIFO, AluValid=0, LongValid Rd=3 data=0x55 -> with WB_BYPASS_EN, RegWr at the next edge (1 cycle); without it, RegWr 2 edges after acceptance, and Pending[3]=1 for one cycle.
